// File: rtl/bow_pkg.sv
// Shared bow definitions: FSM state type and sprite frame sizing used by the
// charge controller and the bow sprite mux.
package bow_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StHold,
    StRelease,
    StCooldown
  } bow_state_t;

  localparam int unsigned BOW_NUM_FRAMES = 6;
  localparam int unsigned BOW_FRAME_W    = 3;

  function automatic int unsigned bow_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bow_tick_counter.sv
// Frame-tick counter with a runtime terminal value; done is sticky until clear,
// last flags that the next tick completes the count.
module bow_tick_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             vga_clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [Width-1:0] last_val,
  output logic             last,
  output logic             done
);

  logic [Width-1:0] count_q;

  assign last = (count_q == last_val);

  always_ff @(posedge vga_clk) begin
    if (Reset || clear) begin
      count_q <= '0;
      done    <= 1'b0;
    end else if (tick && !done) begin
      if (last) begin
        done <= 1'b1;
      end else begin
        count_q <= count_q + Width'(1);
      end
    end
  end

endmodule

// File: rtl/bow_charge_ctrl.sv
// Bow draw/release sequencer: advances the sprite frame on frame ticks while fire
// is held and emits a one-cycle launch carrying the charge level on release.
module bow_charge_ctrl
  import bow_pkg::*;
#(
  parameter int unsigned TICKS_PER_FRAME  = 6,
  parameter int unsigned NUM_FRAMES       = BOW_NUM_FRAMES,
  parameter int unsigned MIN_LAUNCH_FRAME = 1,
  parameter int unsigned COOLDOWN_TICKS   = 20
) (
  input  logic                   vga_clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic                   fire_btn,
  input  logic                   arrow_busy,
  output logic [BOW_FRAME_W-1:0] frame_sel,
  output logic                   launch,
  output logic [BOW_FRAME_W-1:0] launch_power,
  output logic                   charging
);

  localparam int unsigned CntMax = bow_max(TICKS_PER_FRAME, COOLDOWN_TICKS);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]        StepLast  = CntW'(TICKS_PER_FRAME - 1);
  localparam logic [CntW-1:0]        CoolLast  = CntW'(COOLDOWN_TICKS - 1);
  localparam logic [BOW_FRAME_W-1:0] LastFrame = BOW_FRAME_W'(NUM_FRAMES - 1);
  localparam logic [BOW_FRAME_W-1:0] MinFrame  = BOW_FRAME_W'(MIN_LAUNCH_FRAME);

  bow_state_t             state_q, state_d;
  logic [BOW_FRAME_W-1:0] frame_sel_q, frame_sel_d;
  logic [BOW_FRAME_W-1:0] launch_power_q;
  logic                   launch_q, charging_q;

  logic            cnt_clear, cnt_tick, cnt_last, cnt_done, step_wrap;
  logic [CntW-1:0] cnt_last_val;

  assign cnt_last_val = (state_q == StCooldown) ? CoolLast : StepLast;
  assign cnt_tick     = frame_tick && ((state_q == StDraw) || (state_q == StCooldown));
  // Guarded on LastFrame so a draw resumed from a saturated frame cannot overflow.
  assign step_wrap    = (state_q == StDraw) && fire_btn && frame_tick && cnt_last &&
                        (frame_sel_q != LastFrame);
  assign cnt_clear    = (state_d != state_q) || step_wrap;

  bow_tick_counter #(
    .Width (CntW)
  ) u_tick_counter (
    .vga_clk  (vga_clk),
    .Reset    (Reset),
    .clear    (cnt_clear),
    .tick     (cnt_tick),
    .last_val (cnt_last_val),
    .last     (cnt_last),
    .done     (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    frame_sel_d = frame_sel_q;
    unique case (state_q)
      StIdle: begin
        if (frame_tick) frame_sel_d = '0;
        if (fire_btn && !arrow_busy) state_d = StDraw;
      end
      StDraw, StHold: begin
        // Release takes priority over any coincident frame tick.
        if (!fire_btn) begin
          state_d = ((frame_sel_q >= MinFrame) && !arrow_busy) ? StRelease : StIdle;
        end else if (frame_sel_q == LastFrame) begin
          state_d = StHold;
        end else if (step_wrap) begin
          frame_sel_d = frame_sel_q + BOW_FRAME_W'(1);
          if (frame_sel_d == LastFrame) state_d = StHold;
        end
      end
      StRelease: state_d = StCooldown;
      StCooldown: begin
        if (frame_tick) frame_sel_d = '0;
        if (cnt_done && !fire_btn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q        <= StIdle;
      frame_sel_q    <= '0;
      launch_q       <= 1'b0;
      launch_power_q <= '0;
      charging_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_sel_q <= frame_sel_d;
      charging_q  <= (state_d == StDraw) || (state_d == StHold);
      launch_q    <= (state_q == StRelease);
      if (state_q == StRelease) launch_power_q <= frame_sel_q;
    end
  end

  assign frame_sel    = frame_sel_q;
  assign launch       = launch_q;
  assign launch_power = launch_power_q;
  assign charging     = charging_q;

endmodule

// File: tb/tb_bow_charge_ctrl.sv
// Bench for bow_charge_ctrl: directed scenarios with literal expectations plus
// randomized stimulus, all checked every cycle against a charge-level model.
module tb_bow_charge_ctrl;

  localparam int TPF  = 6;
  localparam int NF   = 6;
  localparam int MINF = 1;
  localparam int CD   = 20;

  logic       vga_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       fire_btn = 1'b0;
  logic       arrow_busy = 1'b0;
  logic [2:0] frame_sel, launch_power;
  logic       launch, charging;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  bow_charge_ctrl #(
    .TICKS_PER_FRAME  (TPF),
    .NUM_FRAMES       (NF),
    .MIN_LAUNCH_FRAME (MINF),
    .COOLDOWN_TICKS   (CD)
  ) dut (
    .vga_clk      (vga_clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .fire_btn     (fire_btn),
    .arrow_busy   (arrow_busy),
    .frame_sel    (frame_sel),
    .launch       (launch),
    .launch_power (launch_power),
    .charging     (charging)
  );

  // Model: the frame shown while drawing is the starting frame plus one per TPF
  // ticks counted since the draw began, saturated at the last frame.
  typedef enum int {MIdle, MDraw, MFire, MCool} mode_t;
  mode_t m_mode   = MIdle;
  int    m_frame  = 0;
  int    m_base   = 0;
  int    m_ticks  = 0;
  int    m_cool   = 0;
  int    m_power  = 0;
  int    m_launch = 0;
  int    m_tmp;

  always @(posedge vga_clk) begin
    m_launch = 0;
    if (Reset) begin
      m_mode  = MIdle;
      m_frame = 0;
      m_power = 0;
    end else begin
      case (m_mode)
        MIdle: begin
          if (frame_tick) m_frame = 0;
          if (fire_btn && !arrow_busy) begin
            m_mode  = MDraw;
            m_base  = m_frame;
            m_ticks = 0;
          end
        end
        MDraw: begin
          if (!fire_btn) begin
            m_mode = (m_frame >= MINF && !arrow_busy) ? MFire : MIdle;
          end else if (frame_tick) begin
            m_ticks = m_ticks + 1;
            m_tmp   = m_base + m_ticks / TPF;
            m_frame = (m_tmp > NF - 1) ? NF - 1 : m_tmp;
          end
        end
        MFire: begin
          m_launch = 1;
          m_power  = m_frame;
          m_mode   = MCool;
          m_cool   = 0;
        end
        default: begin
          if (m_cool >= CD && !fire_btn) m_mode = MIdle;
          else if (frame_tick) m_cool = m_cool + 1;
          if (frame_tick) m_frame = 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: present inputs, let the edge pass, compare against the model.
  task automatic step(input bit t);
    frame_tick = t;
    @(posedge vga_clk);
    #2;
    frame_tick = 1'b0;
    chk("model.frame_sel", int'(frame_sel), m_frame);
    chk("model.launch", int'(launch), m_launch);
    chk("model.launch_power", int'(launch_power), m_power);
    chk("model.charging", int'(charging), (m_mode == MDraw) ? 1 : 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
  endtask

  int launches;

  initial begin
    // Reset with fire held: everything quiet until Reset drops.
    Reset    = 1'b1;
    fire_btn = 1'b1;
    step(1'b0);
    step(1'b1);
    chk("reset.frame_sel", int'(frame_sel), 0);
    chk("reset.launch", int'(launch), 0);
    chk("reset.launch_power", int'(launch_power), 0);
    chk("reset.charging", int'(charging), 0);
    Reset = 1'b0;
    step(1'b0);
    chk("draw_entry.charging", int'(charging), 1);

    // Full draw over 40 ticks.
    for (int k = 1; k <= 40; k++) begin
      step(1'b1);
      chk("full_draw.frame_sel", int'(frame_sel), (k / TPF > NF - 1) ? NF - 1 : k / TPF);
      step(1'b0);
      step(1'b0);
    end
    fire_btn = 1'b0;
    step(1'b0);
    chk("full_release.charging", int'(charging), 0);
    chk("full_release.no_early_launch", int'(launch), 0);
    step(1'b0);
    chk("full_launch.launch", int'(launch), 1);
    chk("full_launch.power", int'(launch_power), 5);
    step(1'b0);
    chk("full_launch.one_cycle", int'(launch), 0);

    // Held button through cooldown never redraws.
    fire_btn = 1'b1;
    launches = 0;
    for (int i = 0; i < 50; i++) begin
      ticks(1);
      launches += int'(charging) + int'(launch);
    end
    chk("cooldown_hold.no_redraw", launches, 0);
    chk("cooldown_hold.frame_sel", int'(frame_sel), 0);
    fire_btn = 1'b0;
    step(1'b0);
    step(1'b0);
    fire_btn = 1'b1;
    step(1'b0);
    chk("redraw.charging", int'(charging), 1);

    // Short hold at frame 0: abort without launch.
    ticks(4);
    fire_btn = 1'b0;
    step(1'b0);
    chk("short.charging", int'(charging), 0);
    step(1'b0);
    chk("short.no_launch", int'(launch), 0);
    step(1'b0);
    chk("short.no_launch2", int'(launch), 0);

    // Release at frame 3 while an arrow is in flight.
    fire_btn = 1'b1;
    step(1'b0);
    ticks(18);
    chk("busy.frame_before", int'(frame_sel), 3);
    arrow_busy = 1'b1;
    fire_btn   = 1'b0;
    step(1'b0);
    chk("busy.charging", int'(charging), 0);
    step(1'b0);
    chk("busy.no_launch", int'(launch), 0);
    chk("busy.frame_held", int'(frame_sel), 3);
    arrow_busy = 1'b0;
    step(1'b1);
    chk("busy.frame_cleared", int'(frame_sel), 0);

    // Release coinciding with the 12th tick: no advance.
    fire_btn = 1'b1;
    step(1'b0);
    ticks(11);
    fire_btn = 1'b0;
    step(1'b1);
    chk("coincide.frame_sel", int'(frame_sel), 1);
    step(1'b0);
    chk("coincide.launch", int'(launch), 1);
    chk("coincide.power", int'(launch_power), 1);
    ticks(21);

    // Randomized traffic, including occasional mid-operation resets.
    for (int i = 0; i < 6000; i++) begin
      Reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) fire_btn = ~fire_btn;
      if ($urandom_range(0, 59) == 0) arrow_busy = ~arrow_busy;
      step($urandom_range(0, 3) == 0);
    end
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
